// File: rtl/execute_ctrl_pkg.sv
// Shared types and constants for the LEGv8 execute-stage hazard/sequencing controller.
// Feature macro used by this block: EXEC_CTRL_FWD_EN (ALU operand forwarding).
package execute_ctrl_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } ctrl_state_t;

   typedef logic [3:0] cond_t;

   localparam cond_t COND_EQ = 4'h0;
   localparam cond_t COND_NE = 4'h1;
   localparam cond_t COND_HS = 4'h2;
   localparam cond_t COND_LO = 4'h3;
   localparam cond_t COND_MI = 4'h4;
   localparam cond_t COND_PL = 4'h5;
   localparam cond_t COND_VS = 4'h6;
   localparam cond_t COND_VC = 4'h7;
   localparam cond_t COND_HI = 4'h8;
   localparam cond_t COND_LS = 4'h9;
   localparam cond_t COND_GE = 4'hA;
   localparam cond_t COND_LT = 4'hB;
   localparam cond_t COND_GT = 4'hC;
   localparam cond_t COND_LE = 4'hD;
   localparam cond_t COND_AL = 4'hE;

   localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/cond_eval.sv
// B.cond condition evaluator: decides taken from a condition code and {N,Z,C,V}.
module cond_eval
   import execute_ctrl_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] nzcv_i,
   output logic       taken_o
);

   logic n, z, c, v;

   assign {n, z, c, v} = nzcv_i;

   always_comb begin
      taken_o = 1'b1;
      case (cond_i)
         COND_EQ: taken_o = z;
         COND_NE: taken_o = !z;
         COND_HS: taken_o = c;
         COND_LO: taken_o = !c;
         COND_MI: taken_o = n;
         COND_PL: taken_o = !n;
         COND_VS: taken_o = v;
         COND_VC: taken_o = !v;
         COND_HI: taken_o = c && !z;
         COND_LS: taken_o = !(c && !z);
         COND_GE: taken_o = (n == v);
         COND_LT: taken_o = (n != v);
         COND_GT: taken_o = !z && (n == v);
         COND_LE: taken_o = !(!z && (n == v));
         default: taken_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/execute_ctrl.sv
// Execute-stage controller: NZCV register, branch resolution, RAW hazard stalls and forwarding.
// Define EXEC_CTRL_FWD_EN to enable forwarding (only load-use hazards stall then).
module execute_ctrl
   import execute_ctrl_pkg::*;
#(
   parameter int unsigned REG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] rs1_D,
   input  logic [REG_W-1:0] rs2_D,
   input  logic [REG_W-1:0] rs1_E,
   input  logic [REG_W-1:0] rs2_E,
   input  logic [REG_W-1:0] rd_E,
   input  logic [REG_W-1:0] rd_M,
   input  logic [REG_W-1:0] rd_W,
   input  logic             regWrite_E,
   input  logic             regWrite_M,
   input  logic             regWrite_W,
   input  logic             memRead_E,
   input  logic             uncondBranch_E,
   input  logic             cbz_E,
   input  logic             bcond_E,
   input  logic [3:0]       cond_E,
   input  logic             setFlags_E,
   input  logic             zero_E,
   input  logic             negative_E,
   input  logic             carry_E,
   input  logic             overflow_E,
   output logic             pcSrc_E,
   output logic             stall_F,
   output logic             stall_D,
   output logic             flush_D,
   output logic             flush_E,
   output logic [1:0]       fwdA_E,
   output logic [1:0]       fwdB_E,
   output logic [3:0]       flags_q
);

   ctrl_state_t state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [3:0]  nzcv_q, nzcv_d;
   logic        cond_taken, pc_src, stalling, hz_e;
   logic [1:0]  need, remain_old, remain_new;
   fwd_sel_t    fwd_a, fwd_b;

   function automatic logic produces(input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rd,
                                     input logic we);
      return we && (rd != REG_W'(XZR)) && (rs == rd);
   endfunction

   cond_eval u_cond_eval (
      .cond_i  (cond_E),
      .nzcv_i  (nzcv_q),
      .taken_o (cond_taken)
   );

   assign hz_e = produces(rs1_D, rd_E, regWrite_E) || produces(rs2_D, rd_E, regWrite_E);

`ifdef EXEC_CTRL_FWD_EN
   assign need  = (memRead_E && hz_e) ? 2'd1 : 2'd0;
   assign fwd_a = produces(rs1_E, rd_M, regWrite_M) ? FWD_M :
                  produces(rs1_E, rd_W, regWrite_W) ? FWD_W : FWD_RF;
   assign fwd_b = produces(rs2_E, rd_M, regWrite_M) ? FWD_M :
                  produces(rs2_E, rd_W, regWrite_W) ? FWD_W : FWD_RF;
`else
   logic hz_m;
   logic unused_fwd_inputs;

   // W producers never stall: the register file writes through.
   assign hz_m  = produces(rs1_D, rd_M, regWrite_M) || produces(rs2_D, rd_M, regWrite_M);
   assign need  = hz_e ? 2'd2 : (hz_m ? 2'd1 : 2'd0);
   assign fwd_a = FWD_RF;
   assign fwd_b = FWD_RF;
   assign unused_fwd_inputs = ^{rs1_E, rs2_E, rd_W, regWrite_W, memRead_E};
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      nzcv_d     = nzcv_q;
      stalling   = 1'b0;
      remain_old = 2'd0;
      remain_new = 2'd0;
      pc_src     = uncondBranch_E || (cbz_E && zero_E) || (bcond_E && cond_taken);

      // cnt counts stall cycles still owed after the current one.
      if (pc_src) begin
         state_d = RUN;
         cnt_d   = 2'd0;
      end else begin
         case (state_q)
            STALL: begin
               stalling   = 1'b1;
               remain_old = cnt_q - 2'd1;
            end
            default: stalling = (need != 2'd0);
         endcase
         if (stalling) begin
            remain_new = (need != 2'd0) ? need - 2'd1 : 2'd0;
            cnt_d      = (remain_old > remain_new) ? remain_old : remain_new;
            state_d    = (cnt_d == 2'd0) ? RUN : STALL;
         end else begin
            state_d = RUN;
            cnt_d   = 2'd0;
         end
      end

      if (setFlags_E && !(pc_src || stalling)) begin
         nzcv_d = {negative_E, zero_E, carry_E, overflow_E};
      end
   end

   always_comb begin
      pcSrc_E = reset && pc_src;
      stall_F = reset && stalling;
      stall_D = reset && stalling;
      flush_D = reset && pc_src;
      flush_E = reset && (pc_src || stalling);
      fwdA_E  = reset ? fwd_a : FWD_RF;
      fwdB_E  = reset ? fwd_b : FWD_RF;
      flags_q = reset ? nzcv_q : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q   <= 2'd0;
         nzcv_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         nzcv_q  <= nzcv_d;
      end
   end

endmodule

// File: tb/tb_execute_ctrl.sv
// Self-checking bench for execute_ctrl: directed scenarios plus randomized traffic vs. a model.
// Honours EXEC_CTRL_FWD_EN the same way the design does.
module tb_execute_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
   logic       regWrite_E, regWrite_M, regWrite_W, memRead_E;
   logic       uncondBranch_E, cbz_E, bcond_E, setFlags_E;
   logic [3:0] cond_E;
   logic       zero_E, negative_E, carry_E, overflow_E;
   logic       pcSrc_E, stall_F, stall_D, flush_D, flush_E;
   logic [1:0] fwdA_E, fwdB_E;
   logic [3:0] flags_q;

   int n_checks = 0;
   int n_fails  = 0;

   // Packed observation: {pcSrc, stall_F, stall_D, flush_D, flush_E, fwdA, fwdB, flags}
   localparam logic [12:0] V_IDLE  = 13'b0;
   localparam logic [12:0] V_STALL = {5'b01101, 8'b0};
   localparam logic [12:0] V_TAKEN = {5'b10011, 8'b0};

   always #5 clk = ~clk;

   execute_ctrl #(.REG_W(5)) dut (
      .clk            (clk),
      .reset          (reset),
      .rs1_D          (rs1_D),
      .rs2_D          (rs2_D),
      .rs1_E          (rs1_E),
      .rs2_E          (rs2_E),
      .rd_E           (rd_E),
      .rd_M           (rd_M),
      .rd_W           (rd_W),
      .regWrite_E     (regWrite_E),
      .regWrite_M     (regWrite_M),
      .regWrite_W     (regWrite_W),
      .memRead_E      (memRead_E),
      .uncondBranch_E (uncondBranch_E),
      .cbz_E          (cbz_E),
      .bcond_E        (bcond_E),
      .cond_E         (cond_E),
      .setFlags_E     (setFlags_E),
      .zero_E         (zero_E),
      .negative_E     (negative_E),
      .carry_E        (carry_E),
      .overflow_E     (overflow_E),
      .pcSrc_E        (pcSrc_E),
      .stall_F        (stall_F),
      .stall_D        (stall_D),
      .flush_D        (flush_D),
      .flush_E        (flush_E),
      .fwdA_E         (fwdA_E),
      .fwdB_E         (fwdB_E),
      .flags_q        (flags_q)
   );

   function automatic logic [12:0] obs();
      return {pcSrc_E, stall_F, stall_D, flush_D, flush_E, fwdA_E, fwdB_E, flags_q};
   endfunction

   function automatic logic prod(input logic [4:0] rs, input logic [4:0] rd, input logic we);
      return we && (rd != 5'd31) && (rs == rd);
   endfunction

   // Conditions come in complementary pairs; codes E/F are unconditional.
   function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, r;
      {n, z, cy, v} = f;
      case (c[3:1])
         3'd0:    r = z;
         3'd1:    r = cy;
         3'd2:    r = n;
         3'd3:    r = v;
         3'd4:    r = cy && !z;
         3'd5:    r = (n == v);
         3'd6:    r = !z && (n == v);
         default: r = 1'b1;
      endcase
      return (c[3:1] != 3'd7 && c[0]) ? !r : r;
   endfunction

   function automatic logic [4:0] rreg();
      int unsigned r;
      r = $urandom_range(0, 4);
      return (r == 4) ? 5'd31 : 5'(r);
   endfunction

   task automatic clear_inputs();
      reset = 1'b1;
      {rs1_D, rs2_D, rs1_E, rs2_E} = {4{5'd31}};
      {rd_E, rd_M, rd_W} = {3{5'd31}};
      {regWrite_E, regWrite_M, regWrite_W, memRead_E} = 4'b0;
      {uncondBranch_E, cbz_E, bcond_E, setFlags_E} = 4'b0;
      cond_E = 4'h0;
      {zero_E, negative_E, carry_E, overflow_E} = 4'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      uncondBranch_E = 1'b1;
      regWrite_E = 1'b1; rd_E = 5'd3; rs1_D = 5'd3;
      regWrite_M = 1'b1; rd_M = 5'd4; rs1_E = 5'd4;
      #4;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fails++; $display("FAIL reset_forced: got %b, expected %b", obs(), V_IDLE);
      end
      tick();
      clear_inputs();
      #4;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fails++; $display("FAIL reset_state: got %b, expected %b", obs(), V_IDLE);
      end
      tick();
   endtask

`ifdef EXEC_CTRL_FWD_EN
   task automatic test_hazard_stall();
      do_reset();
      // LDUR X1 in E, ADD X2,X1,X3 in D
      memRead_E = 1'b1; regWrite_E = 1'b1; rd_E = 5'd1; rs1_D = 5'd1; rs2_D = 5'd3;
      #4;
      n_checks++;
      if (obs() !== V_STALL) begin
         n_fails++; $display("FAIL load_use_stall: got %b, expected %b", obs(), V_STALL);
      end
      tick();
      memRead_E = 1'b0; regWrite_E = 1'b0; rd_E = 5'd31;
      regWrite_M = 1'b1; rd_M = 5'd1;
      #4;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fails++; $display("FAIL load_use_release: got %b, expected %b", obs(), V_IDLE);
      end
      tick();
      clear_inputs();
      regWrite_E = 1'b1; rd_E = 5'd2; rs1_E = 5'd1; rs2_E = 5'd3;
      regWrite_W = 1'b1; rd_W = 5'd1;
      #4;
      n_checks++;
      if (obs() !== {5'b0, 2'b01, 2'b00, 4'b0}) begin
         n_fails++; $display("FAIL load_use_fwd_w: got %b, expected %b", obs(),
                             {5'b0, 2'b01, 2'b00, 4'b0});
      end
      tick();
      clear_inputs();
      regWrite_M = 1'b1; rd_M = 5'd1; regWrite_W = 1'b1; rd_W = 5'd1; rs1_E = 5'd1;
      #4;
      n_checks++;
      if (obs() !== {5'b0, 2'b10, 2'b00, 4'b0}) begin
         n_fails++; $display("FAIL fwd_m_priority: got %b, expected %b", obs(),
                             {5'b0, 2'b10, 2'b00, 4'b0});
      end
      rd_M = 5'd31;
      #4;
      n_checks++;
      if (obs() !== {5'b0, 2'b01, 2'b00, 4'b0}) begin
         n_fails++; $display("FAIL fwd_m_xzr: got %b, expected %b", obs(),
                             {5'b0, 2'b01, 2'b00, 4'b0});
      end
      tick();
   endtask
`else
   task automatic test_hazard_stall();
      do_reset();
      // ADD X1 in E, D reads X1: two stall cycles
      regWrite_E = 1'b1; rd_E = 5'd1; rs1_D = 5'd1;
      #4;
      n_checks++;
      if (obs() !== V_STALL) begin
         n_fails++; $display("FAIL no_fwd_stall_c0: got %b, expected %b", obs(), V_STALL);
      end
      tick();
      regWrite_E = 1'b0; rd_E = 5'd31; regWrite_M = 1'b1; rd_M = 5'd1;
      #4;
      n_checks++;
      if (obs() !== V_STALL) begin
         n_fails++; $display("FAIL no_fwd_stall_c1: got %b, expected %b", obs(), V_STALL);
      end
      tick();
      regWrite_M = 1'b0; rd_M = 5'd31; regWrite_W = 1'b1; rd_W = 5'd1;
      #4;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fails++; $display("FAIL no_fwd_stall_done: got %b, expected %b", obs(), V_IDLE);
      end
      tick();
   endtask
`endif

   task automatic test_bcond();
      do_reset();
      setFlags_E = 1'b1; negative_E = 1'b1;
      #4;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fails++; $display("FAIL subs_cycle: got %b, expected %b", obs(), V_IDLE);
      end
      tick();
      clear_inputs();
      bcond_E = 1'b1; cond_E = 4'hB;
      #4;
      n_checks++;
      if (obs() !== {5'b10011, 4'b0, 4'b1000}) begin
         n_fails++; $display("FAIL bcond_lt_taken: got %b, expected %b", obs(),
                             {5'b10011, 4'b0, 4'b1000});
      end
      tick();
      clear_inputs();
      setFlags_E = 1'b1; negative_E = 1'b1;
      #4;
      n_checks++;
      if (obs() !== {9'b0, 4'b1000}) begin
         n_fails++; $display("FAIL subs_again: got %b, expected %b", obs(), {9'b0, 4'b1000});
      end
      tick();
      clear_inputs();
      bcond_E = 1'b1; cond_E = 4'hA;
      #4;
      n_checks++;
      if (obs() !== {9'b0, 4'b1000}) begin
         n_fails++; $display("FAIL bcond_ge_not_taken: got %b, expected %b", obs(),
                             {9'b0, 4'b1000});
      end
      tick();
   endtask

   task automatic test_branch_during_stall();
      do_reset();
      regWrite_E = 1'b1; memRead_E = 1'b1; rd_E = 5'd2; rs2_D = 5'd2;
      #4;
      n_checks++;
      if (obs() !== V_STALL) begin
         n_fails++; $display("FAIL bds_stall: got %b, expected %b", obs(), V_STALL);
      end
      tick();
      regWrite_M = 1'b1; rd_M = 5'd2; cbz_E = 1'b1; zero_E = 1'b1;
      #4;
      n_checks++;
      if (obs() !== V_TAKEN) begin
         n_fails++; $display("FAIL bds_branch_wins: got %b, expected %b", obs(), V_TAKEN);
      end
      tick();
      clear_inputs();
      #4;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fails++; $display("FAIL bds_back_to_run: got %b, expected %b", obs(), V_IDLE);
      end
      tick();
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      setFlags_E = 1'b1;
      {negative_E, zero_E, carry_E, overflow_E} = 4'b1111;
      #4;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fails++; $display("FAIL rms_setflags: got %b, expected %b", obs(), V_IDLE);
      end
      tick();
      clear_inputs();
      regWrite_E = 1'b1; memRead_E = 1'b1; rd_E = 5'd2; rs1_D = 5'd2;
      #4;
      n_checks++;
      if (obs() !== {5'b01101, 4'b0, 4'b1111}) begin
         n_fails++; $display("FAIL rms_stall: got %b, expected %b", obs(),
                             {5'b01101, 4'b0, 4'b1111});
      end
      tick();
      reset = 1'b0; setFlags_E = 1'b1; uncondBranch_E = 1'b1;
      #4;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fails++; $display("FAIL rms_forced: got %b, expected %b", obs(), V_IDLE);
      end
      tick();
      clear_inputs();
      #4;
      n_checks++;
      if (obs() !== V_IDLE) begin
         n_fails++; $display("FAIL rms_after: got %b, expected %b", obs(), V_IDLE);
      end
      tick();
   endtask

   task automatic test_random();
      int          owed;
      int          need;
      logic [3:0]  mflags;
      logic        taken, stall, flush_e;
      logic [1:0]  fa, fb;
      logic [12:0] expv;
      do_reset();
      owed   = 0;
      mflags = 4'b0;
      for (int i = 0; i < 1500; i++) begin
         reset = ($urandom_range(0, 39) != 0);
         rs1_D = rreg(); rs2_D = rreg(); rs1_E = rreg(); rs2_E = rreg();
         rd_E = rreg(); rd_M = rreg(); rd_W = rreg();
         regWrite_E = ($urandom_range(0, 1) == 0);
         regWrite_M = ($urandom_range(0, 1) == 0);
         regWrite_W = ($urandom_range(0, 1) == 0);
         memRead_E = ($urandom_range(0, 2) == 0);
         uncondBranch_E = ($urandom_range(0, 19) == 0);
         cbz_E = ($urandom_range(0, 9) == 0);
         bcond_E = ($urandom_range(0, 5) == 0);
         cond_E = 4'($urandom_range(0, 15));
         setFlags_E = ($urandom_range(0, 2) == 0);
         {negative_E, zero_E, carry_E, overflow_E} = 4'($urandom_range(0, 15));
         if (!reset) begin
            expv   = 13'b0;
            owed   = 0;
            mflags = 4'b0;
         end else begin
            taken = uncondBranch_E || (cbz_E && zero_E) ||
                    (bcond_E && cond_holds(cond_E, mflags));
`ifdef EXEC_CTRL_FWD_EN
            need = (memRead_E && (prod(rs1_D, rd_E, regWrite_E) ||
                                  prod(rs2_D, rd_E, regWrite_E))) ? 1 : 0;
            fa = prod(rs1_E, rd_M, regWrite_M) ? 2'b10 :
                 (prod(rs1_E, rd_W, regWrite_W) ? 2'b01 : 2'b00);
            fb = prod(rs2_E, rd_M, regWrite_M) ? 2'b10 :
                 (prod(rs2_E, rd_W, regWrite_W) ? 2'b01 : 2'b00);
`else
            if (prod(rs1_D, rd_E, regWrite_E) || prod(rs2_D, rd_E, regWrite_E)) need = 2;
            else if (prod(rs1_D, rd_M, regWrite_M) || prod(rs2_D, rd_M, regWrite_M)) need = 1;
            else need = 0;
            fa = 2'b00;
            fb = 2'b00;
`endif
            stall   = !taken && (owed > 0 || need > 0);
            flush_e = taken || stall;
            expv    = {taken, stall, stall, taken, flush_e, fa, fb, mflags};
            if (!stall) owed = 0;
            else owed = (owed - 1 > need - 1) ? owed - 1 : need - 1;
            if (setFlags_E && !flush_e) mflags = {negative_E, zero_E, carry_E, overflow_E};
         end
         #4;
         n_checks++;
         if (obs() !== expv) begin
            n_fails++; $display("FAIL random[%0d]: got %b, expected %b", i, obs(), expv);
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_hazard_stall();
      test_bcond();
      test_branch_during_stall();
      test_reset_mid_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
